// File: rtl/diag_det_engine.sv
// Wrapped-diagonal determinant engine: walks forward (and optionally backward)
// wrapped diagonals of an n x n matrix. Optional DIAG_DET_OVF_EN adds sticky overflow detection.
module diag_det_engine #(
    parameter int DATA_W = 20,
    parameter int IDX_W  = 20,
    parameter int ACC_W  = 40
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [IDX_W-1:0]  size,
    input  logic              mode,
    input  logic [DATA_W-1:0] read_data,
    output logic [IDX_W-1:0]  i,
    output logic [IDX_W-1:0]  j,
    output logic              read,
    output logic              write,
    output logic [ACC_W-1:0]  write_data,
    output logic              busy,
    output logic              finish,
    output logic              ovf
);
    typedef enum logic [2:0] {S_IDLE, S_FWD, S_BWD, S_WRITE, S_DONE} state_t;
    localparam logic [IDX_W-1:0] ONE = IDX_W'(1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  i_q, i_d, j_q, j_d, d_q, d_d, k_q, k_d, n_q, n_d;
    logic              mode_q, mode_d;
    logic [ACC_W-1:0]  prod_q, prod_d, acc_q, acc_d, wd_q, wd_d;
    logic [ACC_W-1:0]  rd_ext, cur, acc_upd;
    logic [IDX_W-1:0]  n_m1;
    logic              accept, walk, fwd, last_k, last_d;

    assign n_m1    = n_q - ONE;
    assign accept  = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;
    assign fwd     = (state_q == S_FWD);
    assign walk    = fwd || (state_q == S_BWD);
    assign last_k  = (k_q == n_m1);
    assign last_d  = (d_q == n_m1);
    assign rd_ext  = ACC_W'($signed(read_data));
    // First element of a diagonal seeds the product; later ones multiply in.
    assign cur     = (k_q == '0) ? rd_ext : prod_q * rd_ext;
    assign acc_upd = fwd ? acc_q + cur : acc_q - cur;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = (size == '0) ? S_WRITE : S_FWD;
            S_FWD:          if (last_k && last_d) state_d = mode_q ? S_WRITE : S_BWD;
            S_BWD:          if (last_k && last_d) state_d = S_WRITE;
            S_WRITE:        state_d = S_DONE;
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        read   = walk;
        write  = (state_q == S_WRITE);
        busy   = walk || (state_q == S_WRITE);
        finish = (state_q == S_DONE);
    end

    always_comb begin
        i_d = i_q; j_d = j_q; d_d = d_q; k_d = k_q; n_d = n_q; mode_d = mode_q;
        prod_d = prod_q; acc_d = acc_q; wd_d = wd_q;
        if (accept) begin
            n_d = size; mode_d = mode;
            acc_d = '0; d_d = '0; k_d = '0; i_d = '0; j_d = '0;
            if (size == '0) wd_d = '0;
        end else if (walk) begin
            prod_d = cur;
            k_d    = last_k ? '0 : k_q + ONE;
            j_d    = k_d;
            if (last_k) begin
                acc_d = acc_upd;
                // Next diagonal starts at row d+1 in both directions; wraps to 0 at phase end.
                d_d   = last_d ? '0 : d_q + ONE;
                i_d   = d_d;
                if (state_d == S_WRITE) wd_d = acc_upd;
            end else if (fwd) begin
                i_d = (i_q == n_m1) ? '0 : i_q + ONE;
            end else begin
                i_d = (i_q == '0) ? n_m1 : i_q - ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_q <= '0; j_q <= '0; d_q <= '0; k_q <= '0; n_q <= '0; mode_q <= 1'b0;
            prod_q <= '0; acc_q <= '0; wd_q <= '0;
        end else begin
            i_q <= i_d; j_q <= j_d; d_q <= d_d; k_q <= k_d; n_q <= n_d; mode_q <= mode_d;
            prod_q <= prod_d; acc_q <= acc_d; wd_q <= wd_d;
        end
    end

    assign i          = i_q;
    assign j          = j_q;
    assign write_data = wd_q;

`ifdef DIAG_DET_OVF_EN
    localparam int FW = ACC_W + DATA_W;
    logic [FW-1:0] full;
    logic          povf, aovf, ovf_q, ovf_d;

    // Product overflows when the exact result does not sign-fit in ACC_W bits.
    assign full = FW'($signed(prod_q)) * FW'($signed(read_data));
    assign povf = (k_q != '0) && (full[FW-1:ACC_W-1] != {(DATA_W+1){full[ACC_W-1]}});
    assign aovf = (fwd ? (acc_q[ACC_W-1] == cur[ACC_W-1]) : (acc_q[ACC_W-1] != cur[ACC_W-1]))
                  && (acc_upd[ACC_W-1] != acc_q[ACC_W-1]);

    always_comb begin
        ovf_d = ovf_q;
        if (accept)    ovf_d = 1'b0;
        else if (walk) ovf_d = ovf_q | povf | (last_k & aovf);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_diag_det_engine.sv
// Scoreboard bench for diag_det_engine: expected results queued at start, checked on write.
module tb_diag_det_engine;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [19:0] size = '0;
    logic        mode = 1'b0;
    logic [19:0] read_data;
    logic [19:0] i, j;
    logic        read, write, busy, finish, ovf;
    logic [39:0] write_data;

    diag_det_engine #(.DATA_W(20), .IDX_W(20), .ACC_W(40)) dut (
        .clk(clk), .reset(rst_n), .start(start), .size(size), .mode(mode),
        .read_data(read_data), .i(i), .j(j), .read(read), .write(write),
        .write_data(write_data), .busy(busy), .finish(finish), .ovf(ovf)
    );

    always #5 clk = ~clk;

`ifdef DIAG_DET_OVF_EN
    localparam bit OVF_EXP = 1'b1;
`else
    localparam bit OVF_EXP = 1'b0;
`endif

    logic [19:0] mem [0:7][0:7];
    assign read_data = mem[i[2:0]][j[2:0]];

    typedef struct {
        logic [39:0] data;
        int          lat;
        int          rds;
        int          rd0;
        bit          ovf;
    } exp_t;

    exp_t sb[$];
    int   tr_i[$], tr_j[$];
    int   n_tests = 0, n_fail = 0;
    int   cyc = 0, start_cyc = 0, rd_cnt = 0;
    exp_t me;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] sext(input logic [19:0] v);
        return {{20{v[19]}}, v};
    endfunction

    // Reference: sum of wrapped forward diagonal products, minus backward ones in mode 0.
    function automatic logic [39:0] model(input int n, input bit md);
        logic [39:0] acc, p;
        acc = '0;
        for (int d = 0; d < n; d++) begin
            p = '0;
            for (int k = 0; k < n; k++)
                p = (k == 0) ? sext(mem[(d+k)%n][k]) : p * sext(mem[(d+k)%n][k]);
            acc = acc + p;
        end
        if (!md) begin
            for (int d = 0; d < n; d++) begin
                p = '0;
                for (int k = 0; k < n; k++)
                    p = (k == 0) ? sext(mem[(d-k+n)%n][k]) : p * sext(mem[(d-k+n)%n][k]);
                acc = acc - p;
            end
        end
        return acc;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (read) begin
            rd_cnt <= rd_cnt + 1;
            tr_i.push_back(int'(i));
            tr_j.push_back(int'(j));
        end
        if (write) begin
            if (sb.size() == 0) chk("spur_wr", 64'(write), 64'd0);
            else begin
                me = sb.pop_front();
                chk("wdata", write_data, me.data);
                chk("lat", 64'(cyc - start_cyc), 64'(me.lat));
                chk("reads", 64'(rd_cnt - me.rd0), 64'(me.rds));
                chk("ovf", 64'(ovf), 64'(me.ovf));
                chk("fin_w", 64'(finish), 64'd0);
            end
        end
    end

    task automatic run(input int n, input bit md, input logic [39:0] exp_d, input int glitch, input bit exp_ovf);
        exp_t e;
        e.data = exp_d;
        e.lat  = (n == 0) ? 1 : (md ? n*n + 1 : 2*n*n + 1);
        e.rds  = (n == 0) ? 0 : (md ? n*n : 2*n*n);
        e.ovf  = exp_ovf;
        @(negedge clk);
        e.rd0 = rd_cnt;
        sb.push_back(e);
        size = 20'(n); mode = md; start = 1'b1; start_cyc = cyc;
        for (int c = 1; sb.size() != 0 && c < 300; c++) begin
            @(negedge clk);
            start = (c == glitch);
            if (c == 3 && n > 1) chk("busy_mid", 64'(busy), 64'd1);
        end
        start = 1'b0;
        chk("done", 64'(sb.size()), 64'd0);
        sb.delete();
        @(negedge clk);
        chk("fin", 64'(finish), 64'd1);
        chk("busy_end", 64'(busy), 64'd0);
        chk("wd_hold", write_data, exp_d);
    endtask

    task automatic load_a();
        mem[0][0] = 20'd1; mem[0][1] = 20'd2; mem[0][2] = 20'd3;
        mem[1][0] = 20'd4; mem[1][1] = 20'd5; mem[1][2] = 20'd6;
        mem[2][0] = 20'd7; mem[2][1] = 20'd8; mem[2][2] = 20'd10;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_i"}, 64'(i), 64'd0);
        chk({tag, "_j"}, 64'(j), 64'd0);
        chk({tag, "_rd"}, 64'(read), 64'd0);
        chk({tag, "_wr"}, 64'(write), 64'd0);
        chk({tag, "_wd"}, write_data, 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_fin"}, 64'(finish), 64'd0);
        chk({tag, "_ovf"}, 64'(ovf), 64'd0);
    endtask

    initial begin
        int trb;
        int fe[5];
        int be[5];
        logic [39:0] neg3;
        fe = '{0, 17, 34, 51, 16};
        be = '{0, 49, 34, 19, 16};
        neg3 = 40'hFF_FFFF_FFFD;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) mem[r][c] = '0;

        #1 chk_reset("rst0");
        @(negedge clk); rst_n = 1'b1;

        load_a();
        run(3, 1'b0, neg3, 0, 1'b0);
        run(3, 1'b1, 40'd230, 0, 1'b0);

        mem[0][0] = 20'd7;
        run(1, 1'b0, 40'd0, 0, 1'b0);
        run(1, 1'b1, 40'd7, 0, 1'b0);
        run(0, 1'b0, 40'd0, 0, 1'b0);

        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) mem[r][c] = 20'($urandom_range(8) - 4);
        trb = tr_i.size();
        run(4, 1'b0, model(4, 1'b0), 0, 1'b0);
        for (int x = 0; x < 5; x++) begin
            chk("trF", 64'(tr_i[trb+x]*16 + tr_j[trb+x]), 64'(fe[x]));
            chk("trB", 64'(tr_i[trb+16+x]*16 + tr_j[trb+16+x]), 64'(be[x]));
        end
        run(4, 1'b1, model(4, 1'b1), 0, 1'b0);

        // Start pulse during BWD must be ignored.
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) mem[r][c] = '0;
        load_a();
        run(3, 1'b0, neg3, 12, 1'b0);

        // Abort mid-FWD by reset; no write may follow.
        @(negedge clk); size = 20'd3; mode = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1 chk_reset("rst_mid");
        @(negedge clk); rst_n = 1'b1;
        repeat (25) @(negedge clk);
        chk("abort_idle", 64'(finish), 64'd0);
        run(3, 1'b0, neg3, 0, 1'b0);

        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) mem[r][c] = 20'h7FFFF;
        run(3, 1'b1, model(3, 1'b1), 0, OVF_EXP);
        load_a();
        run(3, 1'b1, 40'd230, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/diag_det_engine.md
# diag_det_engine

Parametrised wrapped-diagonal determinant engine for an n×n signed matrix held in an external combinational-read memory. Walks every wrapped forward diagonal, then optionally every wrapped backward diagonal, forms each diagonal's product and accumulates the signed total. Writes the result back through a single-cycle write strobe. Successor to the fixed-width 20/40-bit diagonal walker; adds runtime size, start/busy handshake, a forward-only mode and true products.

## Interface
- DATA_W, 20, signed element width (two's complement)
- IDX_W, 20, width of i, j and size
- ACC_W, 40, product/accumulator and write_data width; must be ≥ DATA_W
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- start  in  1  one-cycle request; sampled only in IDLE or DONE
- size  in  IDX_W  matrix dimension n, sampled with start
- mode  in  1  0 = Sarrus (forward minus backward), 1 = forward-only; sampled with start
- read_data  in  DATA_W  element at (i,j), valid in the same cycle
- i  out  IDX_W  row index
- j  out  IDX_W  column index
- read  out  1  memory read enable
- write  out  1  one-cycle result write strobe
- write_data  out  ACC_W  signed result
- busy  out  1  high from the cycle after accepted start until write
- finish  out  1  level, high in DONE
- ovf  out  1  sticky signed-overflow flag (see Configuration)

## Operation
- States: IDLE, FWD, BWD, WRITE, DONE. Reset → IDLE.
- IDLE/DONE + start: latch n and mode; clear acc, d, k, ovf; i=j=0. n=0 → WRITE. Otherwise → FWD.
- FWD: element (i,j) = ((d+k) mod n, k). Both d and k run 0..n-1.
  - k=0: prod ← read_data (sign-extended).
  - k>0: prod ← prod·read_data, truncated to ACC_W.
  - k=n-1: acc ← acc + final product.
  - At the end of each diagonal, d++ and k=0.
  - When d=n-1 and k=n-1: mode 0 → BWD with d=k=0; mode 1 → WRITE.
- BWD: element ((d−k) mod n, k), i.e. i decrements and wraps from 0 to n-1. Products are formed as in FWD. acc ← acc − product at k=n-1. After the last element → WRITE.
- WRITE: write_data ← acc; write=1 for one cycle; → DONE.
- DONE: finish=1. write_data holds. A new start restarts directly; no pass through IDLE is needed.
- start during FWD/BWD/WRITE is ignored.
- n=1: mode 0 gives a−a = 0; mode 1 gives a.
- All arithmetic wraps modulo 2^ACC_W.
- For n=3, mode 0 equals the determinant.

## Timing
- Reset values: i=0, j=0, read=0, write=0, write_data=0, busy=0, finish=0, ovf=0, state IDLE.
- i and j are registered. read=1 exactly in FWD/BWD cycles. The element at the current (i,j) is consumed on the same clock edge.
- One element per cycle, no bubbles between diagonals or between FWD and BWD.
- Latency from the start cycle to the write strobe:
  - mode 0: 2n²+1 cycles
  - mode 1: n²+1 cycles
  - n=0: 1 cycle
- write and finish never overlap; finish rises the cycle after write.
- Reset asserted mid-operation aborts immediately to the reset values. No write is issued.

## Configuration
- DIAG_DET_OVF_EN defined:
  - ovf sets if any product step or acc update overflows signed ACC_W.
  - ovf is sticky until the next accepted start.
  - The result is still the wrapped value.
- Not defined: ovf tied to 0; no detection logic.

## Test plan
- mode 0, n=3, matrix rows [1,2,3],[4,5,6],[7,8,10] → write=1 with write_data=−3 exactly 19 cycles after start, then finish=1.
- Same matrix, mode 1 → write_data=230 at cycle 10; BWD never entered; read high for exactly 9 cycles.
- n=1, element 7: mode 0 → 0; mode 1 → 7. n=0 → write_data=0 one cycle after start, read never high.
- n=4 in mode 0: check i/j sequence. Forward begins (0,0),(1,1),(2,2),(3,3),(1,0). Backward begins (0,0),(3,1),(2,2),(1,3),(1,0). Result must match the software model.
- Reset pulled low mid-FWD → all outputs at reset values; a new start then completes correctly. A start pulse during BWD is ignored.
- With DIAG_DET_OVF_EN, DATA_W=20, ACC_W=40, n=3, all elements 2^19−1 → ovf=1; without the macro, ovf stays 0.
